mood_engine: RTL and testbench

//  Parametrised affective-state core: N_CH saturating drive channels (ch0 = energy, ch1 = stress, ch2.. = free).

---
 rtl/mood_engine.sv | 222 ++++++++++++++++++++++
 tb/tb_mood_engine.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mood_engine.sv
// mood_engine
//   Affective-state core. It keeps N_CH saturating drive channels: ch0 is
//   energy, ch1 is stress, and the remaining channels are free. A four-state
//   physical FSM (AWAKE/TIRED/ASLEEP/DEAD) runs alongside the channels. An
//   emotion-dependent heartbeat divider turns the external tick_en pulse into
//   the internal model tick. Everything runs in a single clock domain.
//
// Parameters
//   N_CH      number of drive channels (at least 2, because ch0 and ch1
//             have fixed roles)
//   WIDTH     bits per channel level
//   INIT_VALS packed reset/revive levels; ch0 occupies the LSBs
//   HB_W      heartbeat counter width; the largest divide ratio is 2**HB_W
//
// Ports
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   tick_en      slow time-base pulse, one clk wide
//   stim_inc     per-channel increment request, sampled on the model tick
//   stim_dec     per-channel decrement request, sampled on the model tick
//   revive       leaves DEAD; ignored in every other state
//   level        packed channel levels (ch0 in the LSBs)
//   band         packed 2-bit bands, the top two bits of each level
//   state        0 AWAKE, 1 TIRED, 2 ASLEEP, 3 DEAD
//   tick_out     registered model tick, one clk wide
//   fell_asleep  one-clk pulse on TIRED->ASLEEP
//   dead         high while state is DEAD
module mood_engine #(
    parameter int                    N_CH      = 3,
    parameter int                    WIDTH     = 7,
    parameter logic [N_CH*WIDTH-1:0] INIT_VALS = {7'd64, 7'd0, 7'd96},
    parameter int                    HB_W      = 3
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    tick_en,
    input  logic [N_CH-1:0]         stim_inc,
    input  logic [N_CH-1:0]         stim_dec,
    input  logic                    revive,
    output logic [N_CH*WIDTH-1:0]   level,
    output logic [N_CH*2-1:0]       band,
    output logic [1:0]              state,
    output logic                    tick_out,
    output logic                    fell_asleep,
    output logic                    dead
);

    typedef enum logic [1:0] {
        AWAKE  = 2'd0,
        TIRED  = 2'd1,
        ASLEEP = 2'd2,
        DEAD   = 2'd3
    } state_t;

    localparam int unsigned    HB_MAX = 2 ** HB_W;
    localparam logic [WIDTH-1:0] LVL_MAX = {WIDTH{1'b1}};

    state_t            cur_state;
    state_t            nxt_state;
    logic [HB_W-1:0]   hb_cnt;
    logic [HB_W-1:0]   ratio_m1;
    int unsigned       ratio;
    logic [WIDTH-1:0]  energy;
    logic [WIDTH-1:0]  stress;
    logic [1:0]        energy_band;
    logic [1:0]        stress_band;
    logic [N_CH-1:0]   ctrl_inc;
    logic [N_CH-1:0]   ctrl_dec;
    logic [N_CH-1:0]   inc_eff;
    logic [N_CH-1:0]   dec_eff;
    logic [N_CH*WIDTH-1:0] level_nxt;
    logic [WIDTH-1:0]  ch_lvl;
    logic              fell_nxt;

    assign energy      = level[0 +: WIDTH];
    assign stress      = level[WIDTH +: WIDTH];
    assign energy_band = energy[WIDTH-1 -: 2];
    assign stress_band = stress[WIDTH-1 -: 2];
    assign state       = cur_state;

    for (genvar g = 0; g < N_CH; g++) begin : g_band
        assign band[2*g +: 2] = level[g*WIDTH + WIDTH - 2 +: 2];
    end

    // Heartbeat divide ratio. A stressed core beats faster, and a sleeping
    // core beats slowest. The result is clamped so that R-1 always fits in
    // the counter.
    always_comb begin
        if (cur_state == ASLEEP) begin
            ratio = 8;
        end else begin
            unique case (stress_band)
                2'd3:    ratio = 1;
                2'd2:    ratio = 2;
                default: ratio = 4;
            endcase
        end
        if (ratio > HB_MAX) begin
            ratio = HB_MAX;
        end
        ratio_m1 = HB_W'(ratio - 1);
    end

    // Heartbeat counter. The compare uses >= so that a ratio which shrinks
    // below the current count fires on the very next tick_en. DEAD keeps the
    // counter at zero, which also guarantees that a revive cycle never ticks.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hb_cnt   <= '0;
            tick_out <= 1'b0;
        end else begin
            tick_out <= 1'b0;
            if (cur_state == DEAD) begin
                hb_cnt <= '0;
            end else if (tick_en) begin
                if (hb_cnt >= ratio_m1) begin
                    hb_cnt   <= '0;
                    tick_out <= 1'b1;
                end else begin
                    hb_cnt <= hb_cnt + 1'b1;
                end
            end
        end
    end

    // Saturating per-channel step. When inc and dec are requested together
    // they cancel, so the level holds.
    always_comb begin
        level_nxt = level;
        ch_lvl    = '0;
        inc_eff   = stim_inc | ctrl_inc;
        dec_eff   = stim_dec | ctrl_dec;
        for (int i = 0; i < N_CH; i++) begin
            ch_lvl = level[i*WIDTH +: WIDTH];
            if (inc_eff[i] && !dec_eff[i] && ch_lvl != LVL_MAX) begin
                level_nxt[i*WIDTH +: WIDTH] = ch_lvl + 1'b1;
            end else if (dec_eff[i] && !inc_eff[i] && ch_lvl != '0) begin
                level_nxt[i*WIDTH +: WIDTH] = ch_lvl - 1'b1;
            end
        end
    end

    // Level register. Levels are frozen while DEAD and reload the initial
    // values on revive.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level <= INIT_VALS;
        end else if (cur_state == DEAD) begin
            if (revive) begin
                level <= INIT_VALS;
            end
        end else if (tick_out) begin
            level <= level_nxt;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_state <= AWAKE;
        end else begin
            cur_state <= nxt_state;
        end
    end

    // Next-state logic. It is evaluated on the model tick against the levels
    // from before the update. Running out of energy overrides every other
    // transition.
    always_comb begin
        nxt_state = cur_state;
        if (cur_state == DEAD) begin
            if (revive) begin
                nxt_state = AWAKE;
            end
        end else if (tick_out) begin
            if (energy == '0) begin
                nxt_state = DEAD;
            end else begin
                unique case (cur_state)
                    AWAKE: begin
                        if (energy_band <= 2'd1) nxt_state = TIRED;
                    end
                    TIRED: begin
                        if (energy_band == 2'd0 && stress_band <= 2'd1) nxt_state = ASLEEP;
                        else if (energy_band >= 2'd2) nxt_state = AWAKE;
                    end
                    ASLEEP: begin
                        if (energy_band == 2'd3) nxt_state = AWAKE;
                    end
                    default: nxt_state = cur_state;
                endcase
            end
        end
    end

    // State-driven outputs. Energy drains while the core is awake or tired.
    // While it sleeps, energy recovers and stress decays.
    always_comb begin
        ctrl_inc = '0;
        ctrl_dec = '0;
        unique case (cur_state)
            AWAKE, TIRED: ctrl_dec[0] = 1'b1;
            ASLEEP: begin
                ctrl_inc[0] = 1'b1;
                ctrl_dec[1] = 1'b1;
            end
            default: ;
        endcase
        fell_nxt = (cur_state == TIRED) && (nxt_state == ASLEEP);
        dead     = (cur_state == DEAD);
    end

    // Registers the fall-asleep pulse so that it lines up with the state change.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fell_asleep <= 1'b0;
        end else begin
            fell_asleep <= fell_nxt;
        end
    end

endmodule

// File: tb/tb_mood_engine.sv
// tb_mood_engine
//   Bench for mood_engine. A reference model works out the result of every
//   tick_en transaction and pushes it to a queue. The result is popped and
//   compared when the DUT produces its tick and its level/state update. A
//   table of hand-worked vectors and several hand-written sequences cover
//   the multi-cycle corner cases.
module tb_mood_engine;

    localparam int N_CH  = 3;
    localparam int WIDTH = 7;
    localparam int HB_W  = 3;
    localparam logic [20:0] INIT = {7'd64, 7'd0, 7'd96};

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        tick_en = 1'b0;
    logic        revive = 1'b0;
    logic [2:0]  stim_inc = '0;
    logic [2:0]  stim_dec = '0;
    logic [20:0] level;
    logic [5:0]  band;
    logic [1:0]  state;
    logic        tick_out;
    logic        fell_asleep;
    logic        dead;

    always #5 clk = ~clk;

    mood_engine #(
        .N_CH      (N_CH),
        .WIDTH     (WIDTH),
        .INIT_VALS (INIT),
        .HB_W      (HB_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .tick_en     (tick_en),
        .stim_inc    (stim_inc),
        .stim_dec    (stim_dec),
        .revive      (revive),
        .level       (level),
        .band        (band),
        .state       (state),
        .tick_out    (tick_out),
        .fell_asleep (fell_asleep),
        .dead        (dead)
    );

    typedef struct {
        logic        tick_out;
        logic [20:0] level;
        logic [5:0]  band;
        logic [1:0]  state;
        logic        fell;
    } expect_t;

    typedef struct {
        logic [2:0]  inc;
        logic [2:0]  dec;
        int          n_txn;
        logic [20:0] exp_level;
        logic [1:0]  exp_state;
    } vec_t;

    expect_t sb_q[$];
    int checks = 0;
    int errors = 0;
    int dut_ticks = 0;
    int fell_seen = 0;

    int m_lvl[3];
    int m_state;
    int m_hb;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h required=%0h", name, actual, expected);
        end
    endtask

    function automatic void model_reset();
        m_lvl[0] = 96;
        m_lvl[1] = 0;
        m_lvl[2] = 64;
        m_state  = 0;
        m_hb     = 0;
    endfunction

    function automatic logic [20:0] model_level();
        return {7'(m_lvl[2]), 7'(m_lvl[1]), 7'(m_lvl[0])};
    endfunction

    function automatic logic [5:0] model_band();
        return {2'(m_lvl[2] / 32), 2'(m_lvl[1] / 32), 2'(m_lvl[0] / 32)};
    endfunction

    function automatic int model_ratio();
        int sb;
        sb = m_lvl[1] / 32;
        if (m_state == 2) return 8;
        if (sb == 3) return 1;
        if (sb == 2) return 2;
        return 4;
    endfunction

    // Advances the model by one model tick, using the levels from before the update.
    function automatic logic model_tick(input logic [2:0] inc, input logic [2:0] dec);
        int eb, sb, ns;
        logic [2:0] ci, cd;
        logic fell, up, dn;
        eb = m_lvl[0] / 32;
        sb = m_lvl[1] / 32;
        ci = '0;
        cd = '0;
        if (m_state <= 1) cd[0] = 1'b1;
        else if (m_state == 2) begin
            ci[0] = 1'b1;
            cd[1] = 1'b1;
        end
        ns = m_state;
        if (m_lvl[0] == 0) ns = 3;
        else if (m_state == 0 && eb <= 1) ns = 1;
        else if (m_state == 1 && eb == 0 && sb <= 1) ns = 2;
        else if (m_state == 1 && eb >= 2) ns = 0;
        else if (m_state == 2 && eb == 3) ns = 0;
        fell = (m_state == 1 && ns == 2);
        for (int c = 0; c < 3; c++) begin
            up = inc[c] | ci[c];
            dn = dec[c] | cd[c];
            if (up && !dn && m_lvl[c] < 127) m_lvl[c]++;
            else if (dn && !up && m_lvl[c] > 0) m_lvl[c]--;
        end
        m_state = ns;
        return fell;
    endfunction

    // One tick_en transaction, four clocks long. The stimulus is held
    // throughout, so it is still present when the model tick reaches the
    // channels.
    task automatic applyStimulus(input logic [2:0] inc, input logic [2:0] dec);
        expect_t e;
        expect_t got;
        logic fire;
        int r;
        r = model_ratio();
        if (m_state == 3) begin
            fire = 1'b0;
            m_hb = 0;
        end else if (m_hb >= r - 1) begin
            fire = 1'b1;
            m_hb = 0;
        end else begin
            fire = 1'b0;
            m_hb++;
        end
        e.fell = 1'b0;
        if (fire) e.fell = model_tick(inc, dec);
        e.tick_out = fire;
        e.level    = model_level();
        e.band     = model_band();
        e.state    = 2'(m_state);
        sb_q.push_back(e);

        stim_inc = inc;
        stim_dec = dec;
        tick_en  = 1'b1;
        @(negedge clk);
        tick_en = 1'b0;
        got = sb_q.pop_front();
        if (tick_out === 1'b1) dut_ticks++;
        checkOutput("tick_out", 32'(tick_out), 32'(got.tick_out));
        @(negedge clk);
        if (fell_asleep === 1'b1) fell_seen++;
        checkOutput("level", 32'(level), 32'(got.level));
        checkOutput("band", 32'(band), 32'(got.band));
        checkOutput("state", 32'(state), 32'(got.state));
        checkOutput("dead", 32'(dead), 32'(got.state == 2'd3));
        checkOutput("fell_asleep", 32'(fell_asleep), 32'(got.fell));
        @(negedge clk);
        checkOutput("fell_pulse_width", 32'(fell_asleep), 32'd0);
        @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vec_t vecs[5];
        logic [20:0] snap;
        int t0;

        vecs[0] = '{3'b100, 3'b000, 8, {7'd66, 7'd0, 7'd94}, 2'd0};
        vecs[1] = '{3'b010, 3'b000, 4, {7'd66, 7'd1, 7'd93}, 2'd0};
        vecs[2] = '{3'b101, 3'b100, 4, {7'd66, 7'd1, 7'd93}, 2'd0};
        vecs[3] = '{3'b000, 3'b010, 4, {7'd66, 7'd0, 7'd92}, 2'd0};
        vecs[4] = '{3'b000, 3'b010, 4, {7'd66, 7'd0, 7'd91}, 2'd0};

        // Reset, with tick_en toggling while reset is held.
        model_reset();
        repeat (2) @(negedge clk);
        tick_en = 1'b1;
        @(negedge clk);
        tick_en = 1'b0;
        @(negedge clk);
        tick_en = 1'b1;
        @(negedge clk);
        checkOutput("reset_level", 32'(level), 32'(INIT));
        checkOutput("reset_band", 32'(band), 32'(6'b10_00_11));
        checkOutput("reset_state", 32'(state), 32'd0);
        checkOutput("reset_tick_out", 32'(tick_out), 32'd0);
        rst_n   = 1'b1;
        tick_en = 1'b0;
        @(negedge clk);
        checkOutput("post_reset_tick_out", 32'(tick_out), 32'd0);

        // Vector table of hand-worked results at stress band 0, where R is 4.
        foreach (vecs[v]) begin
            for (int i = 0; i < vecs[v].n_txn; i++) applyStimulus(vecs[v].inc, vecs[v].dec);
            checkOutput($sformatf("vec%0d_level", v), 32'(level), 32'(vecs[v].exp_level));
            checkOutput($sformatf("vec%0d_state", v), 32'(state), 32'(vecs[v].exp_state));
        end

        // At stress band 0 while AWAKE, one tick every 4th tick_en.
        t0 = dut_ticks;
        for (int i = 0; i < 8; i++) applyStimulus(3'b001, 3'b000);
        checkOutput("ratio4_ticks", 32'(dut_ticks - t0), 32'd2);

        // Raise stress to saturation while holding energy.
        for (int i = 0; i < 600 && m_lvl[1] < 127; i++) applyStimulus(3'b011, 3'b000);
        checkOutput("stress_max", 32'(level[13:7]), 32'd127);
        t0 = dut_ticks;
        for (int i = 0; i < 8; i++) applyStimulus(3'b011, 3'b000);
        checkOutput("ratio1_ticks", 32'(dut_ticks - t0), 32'd8);
        checkOutput("stress_saturate", 32'(level[13:7]), 32'd127);

        // Hold the pleasure increment for 70 ticks: it saturates and stays.
        for (int i = 0; i < 70; i++) applyStimulus(3'b111, 3'b000);
        checkOutput("pleasure_max", 32'(level[20:14]), 32'd127);
        for (int i = 0; i < 4; i++) applyStimulus(3'b101, 3'b100);
        checkOutput("pleasure_inc_dec_hold", 32'(level[20:14]), 32'd127);

        // Under high stress, energy drains to zero, then the core dies.
        for (int i = 0; i < 300 && m_state != 3; i++) applyStimulus(3'b010, 3'b000);
        checkOutput("dead_state", 32'(state), 32'd3);
        checkOutput("dead_flag", 32'(dead), 32'd1);
        checkOutput("dead_energy", 32'(level[6:0]), 32'd0);
        snap = {7'd127, 7'd127, 7'd0};
        t0 = dut_ticks;
        for (int i = 0; i < 4; i++) applyStimulus(3'b111, 3'b000);
        checkOutput("dead_no_ticks", 32'(dut_ticks - t0), 32'd0);
        checkOutput("dead_frozen", 32'(level), 32'(snap));

        // Revive coincides with tick_en. Revive wins and no tick follows.
        stim_inc = '0;
        revive   = 1'b1;
        tick_en  = 1'b1;
        @(negedge clk);
        revive  = 1'b0;
        tick_en = 1'b0;
        model_reset();
        checkOutput("revive_level", 32'(level), 32'(INIT));
        checkOutput("revive_state", 32'(state), 32'd0);
        checkOutput("revive_tick_out", 32'(tick_out), 32'd0);
        @(negedge clk);
        checkOutput("revive_tick_out2", 32'(tick_out), 32'd0);

        // Revive while AWAKE has no effect.
        applyStimulus(3'b000, 3'b000);
        revive = 1'b1;
        @(negedge clk);
        revive = 1'b0;
        checkOutput("revive_awake_level", 32'(level), 32'(model_level()));
        checkOutput("revive_awake_state", 32'(state), 32'd0);
        for (int i = 0; i < 3; i++) applyStimulus(3'b000, 3'b000);

        // With no stimuli, the core drains to TIRED and then to ASLEEP.
        fell_seen = 0;
        for (int i = 0; i < 400 && m_state != 2; i++) applyStimulus(3'b000, 3'b000);
        checkOutput("asleep_state", 32'(state), 32'd2);
        checkOutput("asleep_energy", 32'(level[6:0]), 32'd30);
        checkOutput("fell_pulse_count", 32'(fell_seen), 32'd1);
        t0 = dut_ticks;
        for (int i = 0; i < 16; i++) applyStimulus(3'b000, 3'b000);
        checkOutput("ratio8_ticks", 32'(dut_ticks - t0), 32'd2);
        for (int i = 0; i < 700 && m_state != 0; i++) applyStimulus(3'b000, 3'b000);
        checkOutput("wake_state", 32'(state), 32'd0);
        checkOutput("wake_energy", 32'(level[6:0]), 32'd97);

        // Reset asserted in the middle of a tick_en burst.
        tick_en = 1'b1;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkOutput("midreset_level", 32'(level), 32'(INIT));
        checkOutput("midreset_state", 32'(state), 32'd0);
        checkOutput("midreset_tick_out", 32'(tick_out), 32'd0);
        @(negedge clk);
        rst_n   = 1'b1;
        tick_en = 1'b0;
        model_reset();
        @(negedge clk);
        checkOutput("midreset_after_tick", 32'(tick_out), 32'd0);
        checkOutput("midreset_after_level", 32'(level), 32'(INIT));
        for (int i = 0; i < 4; i++) applyStimulus(3'b000, 3'b000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
